// File: rtl/snoopy_bus_arbiter.sv
// Shares one memory bus among N_REQ read-only snoopy caches and broadcasts write invalidates. Build option: ARB_FIXED_PRIO_EN.
// Latency: a request seen in ARB_IDLE reaches s_rw_valid next cycle; each completion costs one idle bubble.
// Backpressure: requests wait for s_rw_ready; writes are held off while an invalidate broadcast is pending.
module snoopy_bus_arbiter #(
    parameter int N_REQ      = 2,
    parameter int WIDTH      = 128,
    parameter int MASKW      = WIDTH / 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic [N_REQ-1:0]            m_rw_valid,
    output logic [N_REQ-1:0]            m_rw_ready,
    input  logic [N_REQ*ADDR_WIDTH-1:0] m_rw_addr,
    input  logic [N_REQ-1:0]            m_rw_we,
    input  logic [N_REQ*MASKW-1:0]      m_w_mask,
    input  logic [N_REQ*WIDTH-1:0]      m_w_data,
    input  logic [N_REQ-1:0]            m_w_ce,
    output logic [WIDTH-1:0]            m_r_data,

    output logic [N_REQ-1:0]            m_inv_valid,
    output logic [ADDR_WIDTH-1:0]       m_inv_addr,
    input  logic [N_REQ-1:0]            m_inv_ready,

    output logic                        s_rw_valid,
    input  logic                        s_rw_ready,
    output logic [ADDR_WIDTH-1:0]       s_rw_addr,
    output logic                        s_rw_we,
    output logic [MASKW-1:0]            s_w_mask,
    output logic [WIDTH-1:0]            s_w_data,
    output logic                        s_w_ce,
    input  logic [WIDTH-1:0]            s_r_data,

    output logic [N_REQ-1:0]            grant
);

    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {ARB_IDLE, ARB_BUS}   arb_state_t;
    typedef enum logic {INV_IDLE, INV_BCAST} inv_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [MASKW-1:0]      mask;
        logic [WIDTH-1:0]      data;
        logic                  ce;
    } req_t;

    arb_state_t             arb_state;
    inv_state_t             inv_state;
    logic [N_REQ-1:0]       grant_q;
    logic [IDXW-1:0]        gnt_idx;
    logic [N_REQ-1:0]       inv_done;
    logic [ADDR_WIDTH-1:0]  inv_addr;

    logic [N_REQ-1:0]       eligible;
    logic                   win_vld;
    logic [IDXW-1:0]        win_idx;
    logic [N_REQ-1:0]       win_oh;
    logic                   bus_act;
    logic                   bus_done;
    logic                   wr_done;
    req_t                   gnt_req;
    logic [N_REQ-1:0]       inv_vld;
    logic [N_REQ-1:0]       inv_done_nxt;

    // Writes must not start while caches still hold a stale copy of the previous write.
    assign eligible = m_rw_valid & ~((inv_state != INV_IDLE) ? m_rw_we : '0);

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_vld = 1'b1;
                win_idx = IDXW'(i);
            end
        end
    end
`else
    logic [IDXW-1:0] rr_ptr;
    logic [IDXW-1:0] cand;

    // Scan from farthest to nearest so the first eligible index after the pointer wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDXW'((int'(rr_ptr) + k) % N_REQ);
            if (eligible[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= IDXW'(N_REQ - 1);
        end else if (arb_state == ARB_IDLE && win_vld) begin
            rr_ptr <= win_idx;
        end
    end
`endif

    assign win_oh = N_REQ'(1) << win_idx;

    assign bus_act = (arb_state == ARB_BUS);

    always_comb begin
        gnt_req = '0;
        if (bus_act) begin
            gnt_req.addr = m_rw_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            gnt_req.we   = m_rw_we[gnt_idx];
            gnt_req.mask = m_w_mask[int'(gnt_idx)*MASKW +: MASKW];
            gnt_req.data = m_w_data[int'(gnt_idx)*WIDTH +: WIDTH];
            gnt_req.ce   = m_w_ce[gnt_idx];
        end
    end

    assign bus_done = bus_act && s_rw_ready;
    assign wr_done  = bus_done && gnt_req.we && gnt_req.ce;

    assign s_rw_valid = bus_act;
    assign s_rw_addr  = gnt_req.addr;
    assign s_rw_we    = gnt_req.we;
    assign s_w_mask   = gnt_req.mask;
    assign s_w_data   = gnt_req.data;
    assign s_w_ce     = gnt_req.ce;

    assign m_rw_ready = bus_done ? grant_q : '0;
    assign m_r_data   = s_r_data;
    assign grant      = grant_q;

    assign inv_vld      = (inv_state == INV_BCAST) ? ~inv_done : '0;
    assign inv_done_nxt = inv_done | (inv_vld & m_inv_ready);
    assign m_inv_valid  = inv_vld;
    assign m_inv_addr   = inv_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            arb_state <= ARB_IDLE;
            grant_q   <= '0;
            gnt_idx   <= '0;
        end else begin
            case (arb_state)
                ARB_IDLE: begin
                    if (win_vld) begin
                        grant_q   <= win_oh;
                        gnt_idx   <= win_idx;
                        arb_state <= ARB_BUS;
                    end
                end
                ARB_BUS: begin
                    if (s_rw_ready) begin
                        grant_q   <= '0;
                        arb_state <= ARB_IDLE;
                    end
                end
                default: arb_state <= ARB_IDLE;
            endcase
        end
    end

    // A write can only complete while the broadcast is idle, so the two never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_state <= INV_IDLE;
            inv_done  <= '0;
            inv_addr  <= '0;
        end else begin
            case (inv_state)
                INV_IDLE: begin
                    if (wr_done) begin
                        inv_addr  <= gnt_req.addr;
                        inv_done  <= '0;
                        inv_state <= INV_BCAST;
                    end
                end
                INV_BCAST: begin
                    if (&inv_done_nxt) begin
                        inv_done  <= '0;
                        inv_state <= INV_IDLE;
                    end else begin
                        inv_done  <= inv_done_nxt;
                    end
                end
                default: inv_state <= INV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// Directed bench for snoopy_bus_arbiter: read, contention, write-invalidate, write hold-off, mid-flight reset.
module tb_snoopy_bus_arbiter;

    localparam int N  = 2;
    localparam int W  = 128;
    localparam int M  = W / 8;
    localparam int A  = 32;
    localparam logic [W-1:0] DAT_A5 = {16{8'hA5}};
    localparam logic [W-1:0] DAT_WR = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    localparam logic [W-1:0] DAT_RD = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     m_rw_valid;
    logic [N-1:0]     m_rw_ready;
    logic [N*A-1:0]   m_rw_addr;
    logic [N-1:0]     m_rw_we;
    logic [N*M-1:0]   m_w_mask;
    logic [N*W-1:0]   m_w_data;
    logic [N-1:0]     m_w_ce;
    logic [W-1:0]     m_r_data;
    logic [N-1:0]     m_inv_valid;
    logic [A-1:0]     m_inv_addr;
    logic [N-1:0]     m_inv_ready;
    logic             s_rw_valid;
    logic             s_rw_ready;
    logic [A-1:0]     s_rw_addr;
    logic             s_rw_we;
    logic [M-1:0]     s_w_mask;
    logic [W-1:0]     s_w_data;
    logic             s_w_ce;
    logic [W-1:0]     s_r_data;
    logic [N-1:0]     grant;

    int checks   = 0;
    int failures = 0;
    logic [N-1:0] exp_g [4];

    snoopy_bus_arbiter #(.N_REQ(N), .WIDTH(W), .MASKW(M), .ADDR_WIDTH(A)) dut (
        .clk(clk), .rst(rst),
        .m_rw_valid(m_rw_valid), .m_rw_ready(m_rw_ready), .m_rw_addr(m_rw_addr),
        .m_rw_we(m_rw_we), .m_w_mask(m_w_mask), .m_w_data(m_w_data), .m_w_ce(m_w_ce),
        .m_r_data(m_r_data),
        .m_inv_valid(m_inv_valid), .m_inv_addr(m_inv_addr), .m_inv_ready(m_inv_ready),
        .s_rw_valid(s_rw_valid), .s_rw_ready(s_rw_ready), .s_rw_addr(s_rw_addr),
        .s_rw_we(s_rw_we), .s_w_mask(s_w_mask), .s_w_data(s_w_data), .s_w_ce(s_w_ce),
        .s_r_data(s_r_data),
        .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        m_rw_valid  = '0;
        m_rw_addr   = '0;
        m_rw_we     = '0;
        m_w_mask    = '0;
        m_w_data    = '0;
        m_w_ce      = '0;
        m_inv_ready = '0;
        s_rw_ready  = 1'b0;
        s_r_data    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
`ifdef ARB_FIXED_PRIO_EN
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`else
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`endif
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        check("rst_grant",     grant,       0);
        check("rst_s_valid",   s_rw_valid,  0);
        check("rst_inv_valid", m_inv_valid, 0);
        check("rst_m_ready",   m_rw_ready,  0);
        check("rst_s_addr",    s_rw_addr,   0);
        check("rst_inv_addr",  m_inv_addr,  0);
        rst = 1'b0;

        // Single read with a three-cycle memory
        m_rw_valid = 2'b01;
        m_rw_addr[31:0] = 32'h1000;
        step();
        check("rd_grant",   grant,      2'b01);
        check("rd_s_valid", s_rw_valid, 1);
        check("rd_s_addr",  s_rw_addr,  32'h1000);
        check("rd_s_we",    s_rw_we,    0);
        check("rd_wait_rdy", m_rw_ready, 0);
        step();
        step();
        check("rd_wait_rdy2", m_rw_ready, 0);
        s_r_data   = DAT_A5;
        s_rw_ready = 1'b1;
        settle();
        check("rd_m_ready", m_rw_ready, 2'b01);
        check("rd_m_data",  m_r_data,   DAT_A5);
        m_rw_valid = 2'b00;
        step();
        s_rw_ready = 1'b0;
        settle();
        check("rd_ready_drop", m_rw_ready, 0);
        check("rd_grant_clr",  grant,      0);
        check("rd_s_valid_clr", s_rw_valid, 0);

        // Two requesters reading continuously
        do_reset();
        m_rw_valid = 2'b11;
        m_rw_addr[31:0]  = 32'h100;
        m_rw_addr[63:32] = 32'h200;
        for (int i = 0; i < 4; i++) begin
            step();
            check("cont_grant", grant, exp_g[i]);
            check("cont_addr", s_rw_addr, (exp_g[i] == 2'b01) ? 32'h100 : 32'h200);
            s_rw_ready = 1'b1;
            settle();
            check("cont_ready", m_rw_ready, exp_g[i]);
            step();
            s_rw_ready = 1'b0;
            settle();
            check("cont_bubble", grant, 0);
        end
        m_rw_valid = 2'b00;

        // Write from requester 1 followed by invalidate broadcast
        do_reset();
        m_rw_valid = 2'b10;
        m_rw_we    = 2'b10;
        m_w_ce     = 2'b10;
        m_rw_addr[63:32] = 32'h2040;
        m_w_mask[31:16]  = 16'hFFFF;
        m_w_data[255:128] = DAT_WR;
        step();
        check("wr_grant",  grant,     2'b10);
        check("wr_s_we",   s_rw_we,   1);
        check("wr_s_mask", s_w_mask,  16'hFFFF);
        check("wr_s_data", s_w_data,  DAT_WR);
        check("wr_s_ce",   s_w_ce,    1);
        check("wr_no_inv", m_inv_valid, 0);
        s_rw_ready = 1'b1;
        settle();
        check("wr_m_ready", m_rw_ready, 2'b10);
        step();
        s_rw_ready = 1'b0;
        m_rw_valid = 2'b00;
        m_rw_we    = 2'b00;
        m_w_ce     = 2'b00;
        settle();
        check("inv_c0_valid", m_inv_valid, 2'b11);
        check("inv_addr",     m_inv_addr,  32'h2040);
        check("inv_c0_grant", grant,       0);
        step();
        check("inv_c1_valid", m_inv_valid, 2'b11);
        step();
        m_inv_ready = 2'b01;
        settle();
        check("inv_c2_valid", m_inv_valid, 2'b11);
        step();
        m_inv_ready = 2'b00;
        settle();
        check("inv_c3_valid", m_inv_valid, 2'b10);
        step();
        m_inv_ready = 2'b10;
        settle();
        check("inv_c4_valid", m_inv_valid, 2'b10);
        step();
        m_inv_ready = 2'b00;
        settle();
        check("inv_c5_valid", m_inv_valid, 2'b00);

        // Write hold-off while an invalidate is outstanding; reads still proceed
        m_rw_valid = 2'b10;
        m_rw_we    = 2'b10;
        m_w_ce     = 2'b10;
        m_rw_addr[63:32] = 32'h3000;
        step();
        check("ho_wr1_grant", grant, 2'b10);
        s_rw_ready = 1'b1;
        step();
        s_rw_ready = 1'b0;
        m_rw_valid = 2'b11;
        m_rw_we    = 2'b01;
        m_w_ce     = 2'b01;
        m_rw_addr[31:0]  = 32'h4000;
        m_rw_addr[63:32] = 32'h5000;
        settle();
        check("ho_inv_valid", m_inv_valid, 2'b11);
        check("ho_inv_addr",  m_inv_addr,  32'h3000);
        step();
        check("ho_rd_grant", grant,     2'b10);
        check("ho_rd_we",    s_rw_we,   0);
        check("ho_rd_addr",  s_rw_addr, 32'h5000);
        s_r_data   = DAT_RD;
        s_rw_ready = 1'b1;
        settle();
        check("ho_rd_ready", m_rw_ready, 2'b10);
        check("ho_rd_data",  m_r_data,   DAT_RD);
        m_rw_valid = 2'b01;
        step();
        s_rw_ready = 1'b0;
        settle();
        check("ho_bubble", grant, 0);
        step();
        check("ho_wr_held",  grant,       0);
        check("ho_inv_held", m_inv_valid, 2'b11);
        m_inv_ready = 2'b11;
        step();
        m_inv_ready = 2'b00;
        settle();
        check("ho_inv_clr",   m_inv_valid, 0);
        check("ho_still_idle", grant,      0);
        step();
        check("ho_wr_grant", grant,     2'b01);
        check("ho_wr_we",    s_rw_we,   1);
        check("ho_wr_addr",  s_rw_addr, 32'h4000);
        s_rw_ready = 1'b1;
        step();
        s_rw_ready = 1'b0;
        m_rw_valid = 2'b10;
        m_rw_we    = 2'b00;
        m_w_ce     = 2'b00;
        m_rw_addr[63:32] = 32'h6000;
        settle();
        check("rs_inv_valid", m_inv_valid, 2'b11);
        check("rs_inv_addr",  m_inv_addr,  32'h4000);
        step();
        check("rs_bus_grant", grant, 2'b10);

        // Reset while the bus is owned and an invalidate is pending
        rst = 1'b1;
        step();
        check("rs_grant",     grant,       0);
        check("rs_s_valid",   s_rw_valid,  0);
        check("rs_inv_clr",   m_inv_valid, 0);
        check("rs_m_ready",   m_rw_ready,  0);
        check("rs_s_addr",    s_rw_addr,   0);
        check("rs_inv_addr0", m_inv_addr,  0);
        rst = 1'b0;
        m_rw_valid = 2'b01;
        m_rw_addr[31:0] = 32'h7000;
        step();
        check("post_grant", grant,     2'b01);
        check("post_addr",  s_rw_addr, 32'h7000);
        s_rw_ready = 1'b1;
        settle();
        check("post_ready", m_rw_ready, 2'b01);
        step();
        s_rw_ready = 1'b0;
        m_rw_valid = 2'b00;
        settle();
        check("post_idle", grant, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
